// File: rtl/snn_pkg.sv
// Shared types for the spiking front-end: encoder and LIF neuron state
// encodings, plus a saturating magnitude helper.
package snn_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE   = 2'b00,
    ENC_ENCODE = 2'b01
  } enc_state_t;

  typedef enum logic [1:0] {
    LIF_IDLE      = 2'b00,
    LIF_INTEGRATE = 2'b01,
    LIF_FIRE      = 2'b10,
    LIF_REFRAC    = 2'b11
  } lif_state_t;

  function automatic int unsigned sat_abs(
    input int          v,
    input int unsigned lim
  );
    int unsigned a;
    a = (v < 0) ? int'(-v) : int'(v);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/spike_rate_encoder.sv
// Sigma-delta rate encoder: one signed sample becomes a WINDOW-step
// spike train with a signed weight for the neuron array.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int                    SAMPLE_WIDTH = 8,
  parameter int                    WINDOW       = 16,
  parameter int                    VMEM_WIDTH   = 16,
  parameter logic [VMEM_WIDTH-1:0] WEIGHT_MAG   = 16'd256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                           flush,
  output logic                           spike_out,
  output logic signed [VMEM_WIDTH-1:0]   weight_out,
  output logic                           window_done,
  output logic [$clog2(WINDOW+1)-1:0]    spike_count,
  output logic [1:0]                     state_out
);

  localparam int SW     = SAMPLE_WIDTH;
  localparam int FS     = 1 << (SW - 1);
  localparam int STEP_W = $clog2(WINDOW);
  localparam int CNT_W  = $clog2(WINDOW + 1);

  enc_state_t r_state;
  enc_state_t w_next;

  logic [SW-2:0]         r_mag;
  logic [SW-2:0]         r_acc;
  logic [STEP_W-1:0]     r_step;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_count;
  logic                  r_spike;
  logic                  r_done;
  logic [VMEM_WIDTH-1:0] r_weight;

  logic [SW:0]           w_sum;
  logic                  w_spike;
  logic                  w_last;
  logic                  w_accept;

  assign w_accept = sample_valid && (r_state == ENC_IDLE);
  assign w_last   = (r_step == STEP_W'(WINDOW - 1));
  assign w_sum    = {2'b00, r_acc} + {2'b00, r_mag};
  // sum < 2*FS, so sum >= FS is just the top bits, and sum-FS drops them
  assign w_spike  = |w_sum[SW:SW-1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ENC_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ENC_IDLE:   if (sample_valid) w_next = ENC_ENCODE;
      ENC_ENCODE: if (flush || w_last) w_next = ENC_IDLE;
      default:    w_next = ENC_IDLE;
    endcase
  end

  always_comb begin
    sample_ready = (r_state == ENC_IDLE);
    state_out    = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag    <= '0;
      r_acc    <= '0;
      r_step   <= '0;
      r_cnt    <= '0;
      r_count  <= '0;
      r_spike  <= 1'b0;
      r_done   <= 1'b0;
      r_weight <= '0;
    end else begin
      r_spike <= 1'b0;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_mag    <= (SW-1)'(sat_abs(int'(sample_data), FS - 1));
        r_weight <= (sample_data >= 0) ? WEIGHT_MAG : -WEIGHT_MAG;
        r_acc    <= '0;
        r_step   <= '0;
        r_cnt    <= '0;
      end else if (r_state == ENC_ENCODE) begin
        if (flush) begin
          r_acc <= '0;
        end else begin
          r_spike <= w_spike;
          r_acc   <= w_sum[SW-2:0];
          r_cnt   <= r_cnt + CNT_W'(w_spike);
          r_step  <= r_step + 1'b1;
          if (w_last) begin
            r_done  <= 1'b1;
            r_count <= r_cnt + CNT_W'(w_spike);
          end
        end
      end
    end
  end

  assign spike_out   = r_spike;
  assign weight_out  = r_weight;
  assign window_done = r_done;
  assign spike_count = r_count;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: closed-form rate-code model,
// window_done-driven monitor, directed and random samples.
module tb_spike_rate_encoder;

  localparam int SW = 8;
  localparam int W  = 16;
  localparam int VW = 16;
  localparam int FS = 128;
  localparam int WM = 256;
  localparam int CW = $clog2(W + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  sample_valid = 1'b0;
  logic                  sample_ready;
  logic signed [SW-1:0]  sample_data = '0;
  logic                  flush = 1'b0;
  logic                  spike_out;
  logic signed [VW-1:0]  weight_out;
  logic                  window_done;
  logic [CW-1:0]         spike_count;
  logic [1:0]            state_out;

  spike_rate_encoder #(
    .SAMPLE_WIDTH(SW),
    .WINDOW(W),
    .VMEM_WIDTH(VW),
    .WEIGHT_MAG(16'd256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_data(sample_data),
    .flush(flush),
    .spike_out(spike_out),
    .weight_out(weight_out),
    .window_done(window_done),
    .spike_count(spike_count),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bits;
    int cnt;
    int wt;
    int acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_cnt = 0;
  int   hist = 0;

  always @(posedge clk) cyc++;

  // Spike on step i iff the ideal running count floor(k*mag/FS) steps up.
  function automatic exp_t model(input int s, input int ac);
    exp_t e;
    int   mag;
    mag = (s < 0) ? -s : s;
    if (mag > FS - 1) mag = FS - 1;
    e.bits = 0;
    for (int i = 0; i < W; i++)
      if (((i + 1) * mag / FS) > (i * mag / FS))
        e.bits = e.bits | (1 << (W - 1 - i));
    e.cnt     = W * mag / FS;
    e.wt      = (s >= 0) ? WM : -WM;
    e.acc_cyc = ac;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hist = ((hist << 1) | int'(spike_out)) & ((1 << W) - 1);
      if (window_done) begin
        if (q.size() == 0) begin
          check("unexpected_window_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("spike_pattern", hist, e.bits);
          check("spike_count", int'(spike_count), e.cnt);
          check("weight_out", int'(weight_out), e.wt);
          check("done_latency", cyc, e.acc_cyc + W + 1);
          last_cnt = e.cnt;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!sample_ready && n < 100) begin
      tick();
      n++;
    end
    if (!sample_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int s, input bit push);
    wait_ready();
    sample_valid = 1'b1;
    sample_data  = SW'(s);
    tick();
    sample_valid = 1'b0;
    if (push) q.push_back(model(s, cyc - 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(sample_ready), 1);
    check({tag, "_spike"}, int'(spike_out), 0);
    check({tag, "_weight"}, int'(weight_out), 0);
    check({tag, "_count"}, int'(spike_count), 0);
    check({tag, "_state"}, int'(state_out), 0);
    check({tag, "_done"}, int'(window_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    send(64, 1);
    drain();
    send(-32, 1);
    drain();
    send(-128, 1);
    drain();
    send(0, 1);
    drain();

    // Back-to-back with sample_valid held high.
    sample_valid = 1'b1;
    sample_data  = SW'(127);
    tick();
    q.push_back(model(127, cyc - 1));
    sample_data = SW'(64);
    for (int k = 0; k < W; k++) begin
      check("ready_low_encode", int'(sample_ready), 0);
      tick();
    end
    check("ready_high_idle", int'(sample_ready), 1);
    tick();
    q.push_back(model(64, cyc - 1));
    sample_valid = 1'b0;
    drain();

    // Flush at step 5.
    send(64, 0);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", int'(state_out), 0);
    check("flush_ready", int'(sample_ready), 1);
    check("flush_count_hold", int'(spike_count), last_cnt);
    for (int k = 0; k < 20; k++) begin
      check("flush_spike_low", int'(spike_out), 0);
      tick();
    end

    // Flush in IDLE does not block an accept.
    flush = 1'b1;
    send(-1, 1);
    flush = 1'b0;
    drain();

    // Reset at step 5.
    send(64, 0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_cnt = 0;
    check_reset_outputs("mid_reset");

    send(1, 1);
    drain();
    send(127, 1);
    drain();

    for (int n = 0; n < 30; n++) begin
      int s;
      s = int'($signed(8'($urandom_range(0, 255))));
      send(s, 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Converts signed sensor samples into weighted spike trains that drive the spike_in/weight inputs of the LIF neuron array. Each accepted sample is encoded over a fixed window of WINDOW time steps by first-order sigma-delta rate coding. Spike count is proportional to |sample|; the weight sign carries the sample sign. Sits between the sensor front-end FIFO and the neuron layer.

Parameters:
SAMPLE_WIDTH, 8, width of signed input sample; full scale FS = 2**(SAMPLE_WIDTH-1)
WINDOW, 16, encode steps per sample (>=2)
VMEM_WIDTH, 16, width of signed weight_out; matches neuron membrane width
WEIGHT_MAG, 16'd256, magnitude of emitted weight (must be < 2**(VMEM_WIDTH-1))

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
sample_valid  in  1  sample_data is valid
sample_ready  out  1  encoder can accept a sample (high only in IDLE)
sample_data  in  SAMPLE_WIDTH  signed sample
flush  in  1  synchronous abort of the current window
spike_out  out  1  registered spike, one per encode step max
weight_out  out  VMEM_WIDTH  signed weight paired with spike_out
window_done  out  1  one-cycle pulse with the final step's spike_out
spike_count  out  $clog2(WINDOW+1)  spikes emitted in last completed window
state_out  out  2  debug: 00 IDLE, 01 ENCODE

Behaviour:
- Reset (rst high at an edge): state IDLE; sample_ready=1 combinationally from IDLE; spike_out=0, weight_out=0, window_done=0, spike_count=0, accumulator=0, step counter=0. rst overrides flush and sample_valid.
- IDLE: sample_ready=1. Handshake completes at an edge with sample_valid&sample_ready. On accept:
  - mag = |sample_data|, saturated to FS-1 (-128 -> 127 at default width).
  - weight_out <= +WEIGHT_MAG if sample_data >= 0, else -WEIGHT_MAG.
  - acc <= 0, step <= 0, running count <= 0, state <= ENCODE.
  - sample_data is not sampled in any other state.
- ENCODE: exactly WINDOW cycles, steps 0..WINDOW-1.
  - Each step: sum = acc + mag, computed at SAMPLE_WIDTH+1 bits, unsigned.
  - If sum >= FS: spike_out <= 1, acc <= sum - FS, count++.
  - Else: spike_out <= 0, acc <= sum.
  - mag < FS guarantees at most one spike per step.
  - Spikes per window = floor(mag*WINDOW/FS).
- Timing, for an accept on the edge ending cycle A:
  - Step i executes in cycle A+1+i; its spike_out is visible in cycle A+2+i.
  - On step WINDOW-1: window_done <= 1 and spike_count <= final count (including this step's spike), both visible in cycle A+1+WINDOW; state <= IDLE.
  - Minimum sample period is WINDOW+1 cycles.
- spike_out is low in every cycle not driven by an encode step. weight_out holds its value until the next accept. spike_count holds until the next completed window.
- flush high at an edge while in ENCODE:
  - state <= IDLE, spike_out <= 0, acc cleared.
  - No window_done pulse; spike_count unchanged.
- flush in IDLE: no effect; an accept on the same edge is still taken.
- sample_data = 0: window still runs WINDOW cycles with no spikes; window_done pulses; spike_count = 0.

Decomposition:
- Shared package snn_pkg: enc_state_t enum (ENC_IDLE=2'b00, ENC_ENCODE=2'b01); helper function for saturating absolute value.
- Neuron state encodings also live in snn_pkg.
- No sub-module: the sigma-delta step is a few lines inline.

Test Plan:
- rst held 2 cycles, then released -> sample_ready=1, spike_out=0, weight_out=0, spike_count=0, state_out=00.
- Accept sample 64 (WINDOW=16) -> 8 spikes on odd steps 1,3,...,15; weight_out=+256; window_done with count 8 in cycle A+17.
- Accept -32 -> spikes on steps 3,7,11,15; weight_out=-256; count 4. Accept -128 -> saturates to 127 -> 15 spikes on steps 1..15; weight_out=-256.
- Accept 0 -> no spikes for 16 cycles; window_done pulses; spike_count=0.
- sample_valid held high with 127 then 64 -> second accept exactly 17 cycles after the first; sample_ready low throughout ENCODE.
- Accept 64, flush at step 5 -> IDLE next cycle; spikes after step 5 absent; no window_done; spike_count keeps its prior value. Same with rst at step 5 -> all outputs return to reset values.
